// File: rtl/rf_scoreboard.sv
// Parametrised register file with per-register pending scoreboard, pending count and debug window.
// Optional macro RF_BYPASS_EN enables same-cycle write-to-read forwarding.
module rf_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREGS = 16,
  parameter int AW    = 5,
  parameter int NDBG  = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wen,
  input  logic [AW-1:0]              rd,
  input  logic [XLEN-1:0]            wdata,
  input  logic                       rsv_en,
  input  logic [AW-1:0]              rsv_rd,
  input  logic [AW-1:0]              rs1,
  input  logic [AW-1:0]              rs2,
  output logic [XLEN-1:0]            rdata1,
  output logic [XLEN-1:0]            rdata2,
  output logic                       rs1_busy,
  output logic                       rs2_busy,
  output logic [$clog2(NREGS):0]     pend_cnt,
  output logic [NDBG*XLEN-1:0]       dbg_regs
);

  localparam int IW = $clog2(NREGS);
  localparam int CW = IW + 1;

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pend_next;
  logic             wr_ok;
  logic             rsv_ok;
  logic             cnt_inc;
  logic             cnt_dec;
  logic [IW-1:0]    rd_i;
  logic [IW-1:0]    rsv_i;
  logic [IW-1:0]    rs1_i;
  logic [IW-1:0]    rs2_i;

  // Register 0 and anything beyond the implemented file are never addressable.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && (int'(a) < NREGS);
  endfunction

  assign rd_i  = rd[IW-1:0];
  assign rsv_i = rsv_rd[IW-1:0];
  assign rs1_i = rs1[IW-1:0];
  assign rs2_i = rs2[IW-1:0];

  assign wr_ok  = wen && addr_ok(rd);
  assign rsv_ok = rsv_en && addr_ok(rsv_rd);

  // A reserve on the register being written keeps it pending: the new producer replaces the old.
  assign cnt_inc = rsv_ok && !pending[rsv_i];
  assign cnt_dec = wr_ok && pending[rd_i] && !(rsv_ok && (rsv_i == rd_i));

  always_comb begin
    pend_next = pending;
    if (wr_ok)
      pend_next[rd_i] = 1'b0;
    if (rsv_ok)
      pend_next[rsv_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      if (wr_ok)
        regs[rd_i] <= wdata;
      pending <= pend_next;
      if (cnt_inc && !cnt_dec)
        pend_cnt <= pend_cnt + CW'(1);
      else if (cnt_dec && !cnt_inc)
        pend_cnt <= pend_cnt - CW'(1);
    end
  end

  always_comb begin
    rdata1   = addr_ok(rs1) ? regs[rs1_i] : '0;
    rdata2   = addr_ok(rs2) ? regs[rs2_i] : '0;
    rs1_busy = addr_ok(rs1) && pending[rs1_i];
    rs2_busy = addr_ok(rs2) && pending[rs2_i];
`ifdef RF_BYPASS_EN
    if (wr_ok && (rd == rs1)) begin
      rdata1   = wdata;
      rs1_busy = rsv_ok && (rsv_rd == rs1);
    end
    if (wr_ok && (rd == rs2)) begin
      rdata2   = wdata;
      rs2_busy = rsv_ok && (rsv_rd == rs2);
    end
`endif
  end

  always_comb begin
    dbg_regs = '0;
    for (int i = 0; i < NDBG; i++)
      dbg_regs[i*XLEN +: XLEN] = regs[i];
  end

endmodule

// File: doc/rf_scoreboard.md
Name: rf_scoreboard

Overview:
- Parametrised integer register file for the pipelined core; successor to the fixed 16x32 file.
- Configurable width and depth, two combinational read ports, one write port.
- Adds a per-register pending scoreboard so issue logic can detect in-flight producers and stall.
- Exports a pending-count and a configurable debug window of architectural registers.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 16, physical registers implemented; power of 2, range 2..32.
- AW, 5, architectural register address width.
- NDBG, 8, registers exported on dbg_regs (regs 0..NDBG-1); NDBG <= NREGS.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- wen  in  1  write enable (writeback stage).
- rd  in  AW  write address.
- wdata  in  XLEN  write data.
- rsv_en  in  1  reserve request: mark rsv_rd pending (issue stage).
- rsv_rd  in  AW  register to reserve.
- rs1  in  AW  read address, port 1.
- rs2  in  AW  read address, port 2.
- rdata1  out  XLEN  read data, port 1.
- rdata2  out  XLEN  read data, port 2.
- rs1_busy  out  1  rs1 has a pending producer.
- rs2_busy  out  1  rs2 has a pending producer.
- pend_cnt  out  $clog2(NREGS)+1  number of pending registers.
- dbg_regs  out  NDBG*XLEN  flattened regs[NDBG-1:0]; reg i at bits [i*XLEN +: XLEN].

Behaviour:
- Reset: only when reset_n=0 sampled at a rising clk edge; no asynchronous path.
  - Clears all regs, all pending bits and pend_cnt to 0.
  - Overrides any wen/rsv_en in that cycle.
- Address validity: addr is valid iff addr != 0 and addr < NREGS.
- Write: on the edge with wen=1 and rd valid, regs[rd] <= wdata.
  - Invalid rd: write ignored. Reg 0 stays 0 permanently.
- Read: combinational, zero latency; rdataN = regs[rsN] if rsN valid, else 0.
- Pending set/clear:
  - wen=1 with valid rd clears pending[rd] on the edge.
  - rsv_en=1 with valid rsv_rd sets pending[rsv_rd] on the edge.
  - Invalid rsv_rd: ignored.
- Simultaneous write and reserve, same register: reserve wins; pending stays/becomes 1 and data is still written (new producer replaces old).
- Simultaneous write and reserve, different registers: both take effect.
- Write to a non-pending register: legal; data written, pending unchanged (0).
- Reserve of an already-pending register: pending stays 1, pend_cnt unchanged.
- rsN_busy = pending[rsN] when rsN is valid, else 0.
- pend_cnt: registered count, updated incrementally each edge.
  - +1 when a clear bit gets set.
  - -1 when a set bit gets cleared and not re-reserved.
  - Net 0 when both cases occur in one cycle.
  - Invariant: pend_cnt equals popcount(pending); never exceeds NREGS-1.
- dbg_regs: combinational view of regs[0..NDBG-1], reg 0 always 0.
- Reset asserted mid-operation (with pending bits set): all state clears on that edge; the first write after reset release behaves as a normal write.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: write-to-read forwarding.
  - If wen=1, rd valid and rd == rsN, then rdataN = wdata in the same cycle.
  - In that case rsN_busy = 0, unless rsv_en=1 with rsv_rd == rsN in the same cycle, then rsN_busy = 1.
- Undefined:
  - rdataN shows the old regs[rsN] until after the edge.
  - rsN_busy reflects the registered pending bit only.
- Scoreboard and pend_cnt behaviour is identical in both builds.

Test Plan:
- Reset and zero register: reset_n=0 for 2 cycles, then wen=1 rd=0 wdata=0xDEADBEEF, rs1=0 -> rdata1=0, pend_cnt=0, dbg_regs all 0.
- Write/read, out of range: write x5=0x12345678, then rs1=5 -> rdata1=0x12345678. Write rd=20 (NREGS=16) -> no register changes; rs2=20 -> rdata2=0.
- Reserve/writeback: rsv_en rsv_rd=3 -> next cycle rs1=3 gives rs1_busy=1, pend_cnt=1. wen rd=3 wdata=0xA5 -> next cycle rs1_busy=0, pend_cnt=0, rdata1=0xA5.
- Same-cycle collision: x7 pending, then wen rd=7 and rsv_en rsv_rd=7 together -> x7 stays pending, pend_cnt unchanged at 1, regs[7]=wdata.
- Bypass: x4=0x11, wen rd=4 wdata=0x22 with rs2=4 in the same cycle.
  - With RF_BYPASS_EN: rdata2=0x22 that cycle.
  - Without: rdata2=0x11 that cycle, 0x22 the next.
- Reset mid-operation: reserve x1, x2, x9 (pend_cnt=3), assert reset_n=0 one cycle -> pend_cnt=0, all busy 0, all regs 0.
